// File: rtl/tcam_key_unpack_pkg.sv
// Shared TCAM key layout: bit positions and the unpacked field struct,
// used by both the key builder and the receive-side unpacker.
package tcam_key_unpack_pkg;

    localparam int KEY_W  = 128;
    localparam int RSVD_W = 2;

    localparam int KEY_SRC_IP_MSB   = 127;
    localparam int KEY_SRC_IP_LSB   = 96;
    localparam int KEY_DST_IP_MSB   = 95;
    localparam int KEY_DST_IP_LSB   = 64;
    localparam int KEY_PROTO_MSB    = 63;
    localparam int KEY_PROTO_LSB    = 56;
    localparam int KEY_SRC_PORT_MSB = 55;
    localparam int KEY_SRC_PORT_LSB = 40;
    localparam int KEY_DST_PORT_MSB = 39;
    localparam int KEY_DST_PORT_LSB = 24;
    localparam int KEY_VLAN_MSB     = 23;
    localparam int KEY_VLAN_LSB     = 12;
    localparam int KEY_DSCP_MSB     = 11;
    localparam int KEY_DSCP_LSB     = 6;
    localparam int KEY_IPV4_BIT     = 5;
    localparam int KEY_IPV6_BIT     = 4;
    localparam int KEY_ARP_BIT      = 3;
    localparam int KEY_FRAG_BIT     = 2;
    localparam int KEY_RSVD_MSB     = RSVD_W - 1;
    localparam int KEY_RSVD_LSB     = 0;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [7:0]  ip_proto;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [11:0] vlan_id;
        logic [5:0]  dscp;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_fragmented;
        logic        malformed;
    } key_fields_t;

endpackage

// File: rtl/tcam_key_unpack_fields.sv
// Combinational unpack of a packed TCAM key into fields plus the
// malformed-key check.
module tcam_key_fields
    import tcam_key_unpack_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output key_fields_t      fields
);

    logic v4;
    logic v6;
    logic arp;
    logic frag;
    logic multi_l3;

    always_comb begin
        v4   = key[KEY_IPV4_BIT];
        v6   = key[KEY_IPV6_BIT];
        arp  = key[KEY_ARP_BIT];
        frag = key[KEY_FRAG_BIT];
        // No flag set is a legal non-IP key; two or more is contradictory.
        multi_l3 = (v4 && v6) || (v4 && arp) || (v6 && arp);

        fields.src_ip        = key[KEY_SRC_IP_MSB:KEY_SRC_IP_LSB];
        fields.dst_ip        = key[KEY_DST_IP_MSB:KEY_DST_IP_LSB];
        fields.ip_proto      = key[KEY_PROTO_MSB:KEY_PROTO_LSB];
        fields.src_port      = key[KEY_SRC_PORT_MSB:KEY_SRC_PORT_LSB];
        fields.dst_port      = key[KEY_DST_PORT_MSB:KEY_DST_PORT_LSB];
        fields.vlan_id       = key[KEY_VLAN_MSB:KEY_VLAN_LSB];
        fields.dscp          = key[KEY_DSCP_MSB:KEY_DSCP_LSB];
        fields.is_ipv4       = v4;
        fields.is_ipv6       = v6;
        fields.is_arp        = arp;
        fields.is_fragmented = frag;
        fields.malformed     = (key[KEY_RSVD_MSB:KEY_RSVD_LSB] != '0) || multi_l3
                               || (frag && !v4 && !v6);
    end

endmodule

// File: rtl/tcam_key_unpack.sv
// Receive-side TCAM key decoder: validates and unpacks keys into a registered
// output stage backed by one skid entry, and keeps saturating key counters.
module tcam_key_unpack
    import tcam_key_unpack_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter bit DROP_MALFORMED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [KEY_W-1:0] s_key,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_src_ip,
    output logic [31:0]      m_dst_ip,
    output logic [7:0]       m_ip_proto,
    output logic [15:0]      m_src_port,
    output logic [15:0]      m_dst_port,
    output logic [11:0]      m_vlan_id,
    output logic [5:0]       m_dscp,
    output logic             m_is_ipv4,
    output logic             m_is_ipv6,
    output logic             m_is_arp,
    output logic             m_is_fragmented,
    output logic             m_malformed,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_keys,
    output logic [CNT_W-1:0] cnt_malformed
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // s_ready is purely registered (!skid_valid); m_* hold while m_valid && !m_ready.
    key_fields_t in_f;
    key_fields_t out_q;
    key_fields_t skid_q;
    logic        out_valid;
    logic        skid_valid;
    logic        accept;
    logic        keep;
    logic        can_load;

    tcam_key_fields u_fields (
        .key    (s_key),
        .fields (in_f)
    );

    assign s_ready  = !skid_valid;
    assign accept   = s_valid && s_ready;
    assign keep     = accept && !(DROP_MALFORMED && in_f.malformed);
    assign can_load = !out_valid || m_ready;

    // While the skid entry is full s_ready is low, so accept and skid refill never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (can_load) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= keep;
                if (keep) begin
                    out_q <= in_f;
                end
            end
        end else if (keep) begin
            skid_q     <= in_f;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_keys      <= '0;
            cnt_malformed <= '0;
        end else if (cnt_clr) begin
            cnt_keys      <= '0;
            cnt_malformed <= '0;
        end else if (accept) begin
            if (cnt_keys != CNT_MAX) begin
                cnt_keys <= cnt_keys + CNT_ONE;
            end
            if (in_f.malformed && (cnt_malformed != CNT_MAX)) begin
                cnt_malformed <= cnt_malformed + CNT_ONE;
            end
        end
    end

    assign m_valid         = out_valid;
    assign m_src_ip        = out_q.src_ip;
    assign m_dst_ip        = out_q.dst_ip;
    assign m_ip_proto      = out_q.ip_proto;
    assign m_src_port      = out_q.src_port;
    assign m_dst_port      = out_q.dst_port;
    assign m_vlan_id       = out_q.vlan_id;
    assign m_dscp          = out_q.dscp;
    assign m_is_ipv4       = out_q.is_ipv4;
    assign m_is_ipv6       = out_q.is_ipv6;
    assign m_is_arp        = out_q.is_arp;
    assign m_is_fragmented = out_q.is_fragmented;
    assign m_malformed     = out_q.malformed;

endmodule
